// File: rtl/gpzda_pkg.sv
// rtl/gpzda_pkg.sv - shared frame layout, ASCII constants and FSM types for the ZDA sender
package gpzda_pkg;

    localparam int FRAME_LEN = 38;

    localparam logic [5:0] IDX_TALKER = 6'd1;
    localparam logic [5:0] IDX_ZDA    = 6'd3;
    localparam logic [5:0] IDX_TIME   = 6'd7;
    localparam logic [5:0] IDX_CENTI  = 6'd14;
    localparam logic [5:0] IDX_DAY    = 6'd17;
    localparam logic [5:0] IDX_MONTH  = 6'd20;
    localparam logic [5:0] IDX_YEAR   = 6'd23;
    localparam logic [5:0] IDX_ZH     = 6'd28;
    localparam logic [5:0] IDX_ZM     = 6'd31;
    localparam logic [5:0] IDX_STAR   = 6'd33;
    localparam logic [5:0] IDX_CSUM   = 6'd34;
    localparam logic [5:0] IDX_CR     = 6'd36;
    localparam logic [5:0] IDX_LAST   = 6'(FRAME_LEN - 1);

    localparam logic [7:0] ASCII_DOLLAR  = 8'h24;
    localparam logic [7:0] ASCII_COMMA   = 8'h2C;
    localparam logic [7:0] ASCII_DOT     = 8'h2E;
    localparam logic [7:0] ASCII_STAR    = 8'h2A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    typedef struct packed {
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  second;
        logic [7:0]  centi;
        logic [7:0]  day;
        logic [7:0]  month;
        logic [15:0] year;
        logic [7:0]  zone_hour;
        logic [7:0]  zone_minute;
    } fields_t;

endpackage

// File: rtl/gpzda_sender_if.sv
// rtl/gpzda_sender_if.sv - byte stream valid/ready bundle between the sender and its sink
interface gpzda_sender_if #(
    parameter int B = 8
);
    logic [B-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - 4-bit value to uppercase ASCII hex digit
module nibble_to_ascii
    import gpzda_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb begin
        if (nibble < 4'd10) ascii = ASCII_ZERO + {4'h0, nibble};
        else                ascii = ASCII_UPPER_A + {4'h0, nibble} - 8'd10;
    end
endmodule

// File: rtl/gpzda_sender.sv
// rtl/gpzda_sender.sv - NMEA ZDA sentence generator; zone fields exist only with GPZDA_ZONE_EN
module gpzda_sender
    import gpzda_pkg::*;
#(
    parameter int              B      = 8,
    parameter logic [2*B-1:0]  TALKER = "GP"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  hour,
    input  logic [7:0]  minute,
    input  logic [7:0]  second,
    input  logic [7:0]  centi,
    input  logic [7:0]  day,
    input  logic [7:0]  month,
    input  logic [15:0] year,
`ifdef GPZDA_ZONE_EN
    input  logic [7:0]  zone_hour,
    input  logic [7:0]  zone_minute,
`endif
    gpzda_sender_if.master tx,
    output logic        busy,
    output logic        done
);
    state_t       state, state_next;
    logic [5:0]   idx;
    logic [7:0]   csum;
    fields_t      sh, fields_in;
    logic         hs;
    logic         use_nib;
    logic [3:0]   nib;
    logic [7:0]   nib_ascii;
    logic [B-1:0] byte_c, tx_byte;

    always_comb begin
        fields_in = '{hour: hour, minute: minute, second: second, centi: centi,
                      day: day, month: month, year: year,
`ifdef GPZDA_ZONE_EN
                      zone_hour: zone_hour, zone_minute: zone_minute};
`else
                      zone_hour: 8'h00, zone_minute: 8'h00};
`endif
    end

    nibble_to_ascii u_hex (.nibble(nib), .ascii(nib_ascii));

    // Every digit position, BCD or checksum, goes through the single hex mapper.
    always_comb begin
        use_nib = 1'b0;
        nib     = 4'h0;
        byte_c  = '0;
        case (idx)
            6'd0:              byte_c = ASCII_DOLLAR;
            IDX_TALKER:        byte_c = TALKER[2*B-1:B];
            IDX_TALKER + 6'd1: byte_c = TALKER[B-1:0];
            IDX_ZDA:           byte_c = "Z";
            IDX_ZDA + 6'd1:    byte_c = "D";
            IDX_ZDA + 6'd2:    byte_c = "A";
            IDX_ZDA + 6'd3:    byte_c = ASCII_COMMA;
            IDX_TIME:          begin use_nib = 1'b1; nib = sh.hour[7:4];        end
            IDX_TIME + 6'd1:   begin use_nib = 1'b1; nib = sh.hour[3:0];        end
            IDX_TIME + 6'd2:   begin use_nib = 1'b1; nib = sh.minute[7:4];      end
            IDX_TIME + 6'd3:   begin use_nib = 1'b1; nib = sh.minute[3:0];      end
            IDX_TIME + 6'd4:   begin use_nib = 1'b1; nib = sh.second[7:4];      end
            IDX_TIME + 6'd5:   begin use_nib = 1'b1; nib = sh.second[3:0];      end
            IDX_CENTI - 6'd1:  byte_c = ASCII_DOT;
            IDX_CENTI:         begin use_nib = 1'b1; nib = sh.centi[7:4];       end
            IDX_CENTI + 6'd1:  begin use_nib = 1'b1; nib = sh.centi[3:0];       end
            IDX_DAY - 6'd1:    byte_c = ASCII_COMMA;
            IDX_DAY:           begin use_nib = 1'b1; nib = sh.day[7:4];         end
            IDX_DAY + 6'd1:    begin use_nib = 1'b1; nib = sh.day[3:0];         end
            IDX_MONTH - 6'd1:  byte_c = ASCII_COMMA;
            IDX_MONTH:         begin use_nib = 1'b1; nib = sh.month[7:4];       end
            IDX_MONTH + 6'd1:  begin use_nib = 1'b1; nib = sh.month[3:0];       end
            IDX_YEAR - 6'd1:   byte_c = ASCII_COMMA;
            IDX_YEAR:          begin use_nib = 1'b1; nib = sh.year[15:12];      end
            IDX_YEAR + 6'd1:   begin use_nib = 1'b1; nib = sh.year[11:8];       end
            IDX_YEAR + 6'd2:   begin use_nib = 1'b1; nib = sh.year[7:4];        end
            IDX_YEAR + 6'd3:   begin use_nib = 1'b1; nib = sh.year[3:0];        end
            IDX_ZH - 6'd1:     byte_c = ASCII_COMMA;
            IDX_ZH:            begin use_nib = 1'b1; nib = sh.zone_hour[7:4];   end
            IDX_ZH + 6'd1:     begin use_nib = 1'b1; nib = sh.zone_hour[3:0];   end
            IDX_ZM - 6'd1:     byte_c = ASCII_COMMA;
            IDX_ZM:            begin use_nib = 1'b1; nib = sh.zone_minute[7:4]; end
            IDX_ZM + 6'd1:     begin use_nib = 1'b1; nib = sh.zone_minute[3:0]; end
            IDX_STAR:          byte_c = ASCII_STAR;
            IDX_CSUM:          begin use_nib = 1'b1; nib = csum[7:4];           end
            IDX_CSUM + 6'd1:   begin use_nib = 1'b1; nib = csum[3:0];           end
            IDX_CR:            byte_c = ASCII_CR;
            IDX_LAST:          byte_c = ASCII_LF;
            default:           byte_c = '0;
        endcase
        tx_byte = use_nib ? nib_ascii : byte_c;
    end

    always_comb begin
        state_next = state;
        hs         = (state == ST_SEND) && tx.tx_ready;
        case (state)
            ST_IDLE: if (start) state_next = ST_SEND;
            ST_SEND: if (hs && (idx == IDX_LAST)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx.tx_valid = (state == ST_SEND);
    assign tx.tx_data  = (state == ST_SEND) ? tx_byte : '0;
    assign busy        = (state == ST_SEND);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            csum  <= '0;
            done  <= 1'b0;
            sh    <= '0;
        end else begin
            state <= state_next;
            done  <= hs && (idx == IDX_LAST);
            if (state == ST_IDLE) begin
                if (start) begin
                    sh   <= fields_in;
                    csum <= '0;
                    idx  <= '0;
                end
            end else if (hs) begin
                idx <= (idx == IDX_LAST) ? 6'd0 : idx + 6'd1;
                // Checksum covers everything between '$' and '*'.
                if (idx >= IDX_TALKER && idx <= IDX_ZM + 6'd1)
                    csum <= csum ^ tx_byte[7:0];
            end
        end
    end
endmodule
